mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU instruction-fetch port and data (load/store) port.
- Arbitrates between the two requesters and sequences each transfer through a req/ack memory handshake.
- Returns read data to the requester and produces a stall to freeze the CPU PC while the fetch port is waiting.
- Sits between the Cpu ports (address_instruction, address_data, data_out, width, write_mem) and the memory model/controller.

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch and data ports.
// Define MEM_TIMEOUT_EN to add an ack timeout that completes the transfer with bus_err.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_width,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        bus_err
);

  // state | meaning
  // IDLE  | no transfer outstanding; arbitrate when no valid pulse is showing
  // FETCH | fetch transfer on the memory bus, waiting for mem_ack
  // DATA  | load/store transfer on the memory bus, waiting for mem_ack
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_e;

  localparam int unsigned     SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [31:0]     NOP_INSN   = 32'h0000_0013;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          grant_f, grant_d;
  logic          timed_out;
  logic          xfer_done;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_width_q, mem_width_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;

  assign xfer_done = (state_q != IDLE) && (mem_ack || timed_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_width_q <= mem_width_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  // Grants are held off while a valid pulse is showing so the requester can retire it first.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!if_valid_q && !d_valid_q) begin
          if (d_req && (!if_req || (starve_q < STARVE_MAX))) begin
            grant_d = 1'b1;
          end else if (if_req) begin
            grant_f = 1'b1;
          end
        end
      end
      FETCH, DATA: begin
        if (xfer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_d) begin
      state_d = DATA;
      if (if_req && (starve_q < STARVE_MAX)) starve_d = starve_q + SW'(1);
    end
    if (grant_f) begin
      state_d  = FETCH;
      starve_d = '0;
    end
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_width_d = mem_width_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if (grant_f) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_width_d = 2'b10;
    end
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_width_d = d_width;
    end
    if (xfer_done) begin
      mem_req_d = 1'b0;
      if (state_q == FETCH) begin
        if_valid_d = 1'b1;
        if_rdata_d = timed_out ? NOP_INSN : mem_rdata;
      end else begin
        d_valid_d = 1'b1;
        if (!mem_we_q) d_rdata_d = timed_out ? 32'h0 : mem_rdata;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned   TW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          bus_err_q, bus_err_d;

  // Down-counter reloaded on every grant; terminal count without ack ends the transfer.
  always_comb begin
    timer_d = timer_q;
    if (grant_f || grant_d) begin
      timer_d = TIMER_LOAD;
    end else if ((state_q != IDLE) && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
  end

  assign timed_out = (state_q != IDLE) && (timer_q == '0) && !mem_ack;
  assign bus_err_d = timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timed_out          = 1'b0;
  assign bus_err            = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_width = mem_width_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;

  assign stall = (if_req & ~if_valid_q) | (state_q == DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int unsigned SL  = 2;
  localparam int unsigned TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_width;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        bus_err;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder. 0: random latency 0..3 plus stray acks while idle,
  // 1: ack two cycles after mem_req, 2: ack tied high, 3: ack follows stray_ack.
  int          mem_mode    = 3;
  int          wait_cnt    = -1;
  logic        stray_ack   = 1'b0;
  logic [31:0] rdata_fixed = 32'h0;

  always @(negedge clk) begin
    case (mem_mode)
      2: begin mem_ack = 1'b1; mem_rdata = rdata_fixed; end
      3: begin mem_ack = stray_ack; mem_rdata = rdata_fixed; wait_cnt = -1; end
      default: begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wait_cnt < 0) wait_cnt = (mem_mode == 1) ? 2 : int'($urandom_range(0, 3));
          if (wait_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = (mem_mode == 1) ? rdata_fixed : $urandom;
            wait_cnt  = -1;
          end else begin
            wait_cnt--;
          end
        end else begin
          wait_cnt = -1;
          if (mem_mode == 0 && $urandom_range(0, 7) == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
          end
        end
      end
    endcase
  end

  // Transaction-level reference: who owns the bus, what was latched, what is pending.
  int          owner;    // 0 none, 1 fetch, 2 data
  int          starve;
  int          waited;
  logic        e_req, e_we, e_if_valid, e_d_valid, e_bus_err;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
  logic [1:0]  e_width;

  always @(posedge clk) begin
    bit was_valid;
    bit tmo;
    bit in_rst;
    in_rst = !rst_n;
    if (in_rst) begin
      owner = 0; starve = 0; waited = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_width = 0;
      e_if_valid = 0; e_d_valid = 0; e_bus_err = 0; e_if_rdata = 0; e_d_rdata = 0;
    end else begin
      was_valid  = e_if_valid | e_d_valid;
      e_if_valid = 0; e_d_valid = 0; e_bus_err = 0;
      if (owner != 0) begin
        waited++;
        tmo = 0;
`ifdef MEM_TIMEOUT_EN
        tmo = !mem_ack && (waited >= TO);
`endif
        if (mem_ack || tmo) begin
          if (owner == 1) begin
            e_if_valid = 1;
            e_if_rdata = tmo ? NOP : mem_rdata;
          end else begin
            e_d_valid = 1;
            if (!e_we) e_d_rdata = tmo ? 32'h0 : mem_rdata;
          end
          e_bus_err = tmo;
          owner     = 0;
          e_req     = 0;
        end
      end else if (!was_valid && (if_req || d_req)) begin
        if (d_req && !(if_req && starve >= SL)) begin
          owner = 2; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_width = d_width;
          if (if_req && starve < SL) starve++;
        end else begin
          owner = 1; e_we = 0; e_addr = if_addr; e_width = 2'b10;
          starve = 0;
        end
        e_req  = 1;
        waited = 0;
      end
    end
    #1;
    chk("mem_req", mem_req, e_req);
    chk("if_valid", if_valid, e_if_valid);
    chk("d_valid", d_valid, e_d_valid);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("bus_err", bus_err, e_bus_err);
    if (e_req || in_rst) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_width", mem_width, e_width);
    end
    if ((e_req && e_we) || in_rst) chk("mem_wdata", mem_wdata, e_wdata);
    if (!in_rst) chk("stall", stall, (if_req & ~e_if_valid) | (owner == 2));
  end

  // Waits for the completion pulse of one port, capturing the bus attributes seen on the way.
  task automatic wait_valid(input bit dport, output int cyc, output logic [31:0] a,
                            output logic w, output logic [31:0] wd, output logic [1:0] wid,
                            output bit stall_hi);
    cyc = 0; a = 0; w = 0; wd = 0; wid = 0; stall_hi = 1;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) begin a = mem_addr; w = mem_we; wd = mem_wdata; wid = mem_width; end
      if (dport ? d_valid : if_valid) break;
      if (!stall) stall_hi = 0;
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [1:0]  wid;
    bit          sh;
    string       got;
    string       exp_order;
    logic        prev_req;
    int          rst_hold;
    int          hi;

    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_width = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_width", mem_width, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_valid", d_valid, 0);
    rst_n = 1'b1;

    // Fetch only, ack two cycles after mem_req.
    mem_mode = 1; rdata_fixed = 32'h0050_0093;
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    wait_valid(0, cyc, a, w, wd, wid, sh);
    chk("fetch_latency", cyc, 4);
    chk("fetch_addr", a, 32'h100);
    chk("fetch_we", w, 0);
    chk("fetch_width", wid, 2);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    @(negedge clk);
    if_req = 0;
    @(posedge clk); #1;
    chk("fetch_one_pulse", if_valid, 0);
    chk("fetch_stall_after", stall, 0);

    // Store.
    rdata_fixed = 32'h1234_5678;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_width = 2;
    wait_valid(1, cyc, a, w, wd, wid, sh);
    chk("store_latency", cyc, 4);
    chk("store_we", w, 1);
    chk("store_addr", a, 32'h200);
    chk("store_wdata", wd, 32'hDEAD_BEEF);
    chk("store_width", wid, 2);
    chk("store_stall", sh, 1);
    chk("store_d_rdata_kept", d_rdata, 0);
    @(negedge clk);
    d_req = 0;
    @(posedge clk); #1;
    chk("store_one_pulse", d_valid, 0);

    // Contention with both requests held continuously.
    @(negedge clk);
    if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000; d_width = 2;
    got = ""; prev_req = 0; cyc = 0;
    while (got.len() < 6 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req && !prev_req) got = {got, (mem_addr == 32'h1000) ? "F" : "D"};
      prev_req = mem_req;
    end
    exp_order = "DDFDDF";
    chk("contention_grants", got.len(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("grant_order_%0d", i), (i < got.len()) ? got[i] : 8'h0, exp_order[i]);
    cyc = 0;
    while (!if_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
    chk("contention_last_fetch_done", if_valid, 1);
    @(negedge clk);
    if_req = 0; d_req = 0;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait memory.
    mem_mode = 2; rdata_fixed = 32'h0000_0297;
    @(negedge clk);
    if_req = 1; if_addr = 32'h300;
    wait_valid(0, cyc, a, w, wd, wid, sh);
    chk("zw_latency", cyc, 2);
    chk("zw_rdata", if_rdata, 32'h0000_0297);
    @(posedge clk); #1;
    chk("zw_no_grant_on_valid", mem_req, 0);
    @(posedge clk); #1;
    chk("zw_grant_cycle3", mem_req, 1);
    @(posedge clk); #1;
    chk("zw_second_valid", if_valid, 1);
    mem_mode = 3; stray_ack = 0; rdata_fixed = 32'hCAFE_F00D;
    @(negedge clk);
    if_req = 0;

    // Reset in the middle of a data transfer, then a stray ack.
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h400; d_width = 2;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!mem_req && cyc < 10);
    chk("rstmid_req_seen", mem_req, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_mem_width", mem_width, 0);
    d_req = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    stray_ack = 1;
    @(posedge clk); #1;
    stray_ack = 0;
    @(posedge clk); #1;
    chk("stray_mem_req", mem_req, 0);
    chk("stray_d_valid", d_valid, 0);
    chk("stray_d_rdata", d_rdata, 0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    if_req = 1; if_addr = 32'h500;
    hi = 0; cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) hi++;
      if (if_valid) break;
    end
    chk("tmo_req_cycles", hi, TO);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_if_valid", if_valid, 1);
    chk("tmo_rdata", if_rdata, NOP);
    chk("tmo_req_dropped", mem_req, 0);
    @(negedge clk);
    if_req = 0;
    @(posedge clk); #1;
`endif

    // Randomized traffic with random latencies, stray acks and occasional resets.
    mem_mode = 0;
    rst_hold = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!if_req || if_valid) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || d_valid) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_width = 2'($urandom_range(0, 3));
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1;
      end else if ($urandom_range(0, 249) == 0) begin
        rst_n    = 0;
        rst_hold = 2;
      end
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
